// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared definitions for the 4-bit CPU control path.
//   - Opcode constants (upper nibble of the 8-bit instruction word)
//   - Datapath source-select encodings for {select_b, select_a}
//   - Sequencer state enum
//   - Decoded control bundle produced by instr_decoder
// -----------------------------------------------------------------------------
package cpu_pkg;

    localparam logic [3:0] OP_ADD_A_IM = 4'b0000;
    localparam logic [3:0] OP_MOV_A_B  = 4'b0001;
    localparam logic [3:0] OP_IN_A     = 4'b0010;
    localparam logic [3:0] OP_MOV_A_IM = 4'b0011;
    localparam logic [3:0] OP_MOV_B_A  = 4'b0100;
    localparam logic [3:0] OP_ADD_B_IM = 4'b0101;
    localparam logic [3:0] OP_IN_B     = 4'b0110;
    localparam logic [3:0] OP_MOV_B_IM = 4'b0111;
    localparam logic [3:0] OP_OUT_B    = 4'b1001;
    localparam logic [3:0] OP_OUT_IM   = 4'b1011;
    localparam logic [3:0] OP_JNC      = 4'b1110;
    localparam logic [3:0] OP_JMP      = 4'b1111;

    // {select_b, select_a}
    localparam logic [1:0] SEL_A    = 2'b00;
    localparam logic [1:0] SEL_B    = 2'b01;
    localparam logic [1:0] SEL_IN   = 2'b10;
    localparam logic [1:0] SEL_ZERO = 2'b11;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_FETCH = 2'd1,
        ST_EXEC  = 2'd2
    } state_t;

    typedef struct packed {
        logic [1:0] sel;      // {select_b, select_a}
        logic [3:0] load;     // one-hot write strobe: [0]=A [1]=B [2]=OUT [3]=spare
        logic       use_imm;  // drive the instruction immediate onto im
        logic       is_jmp;
        logic       is_jnc;
        logic       illegal;
    } ctrl_t;

endpackage

// File: rtl/instr_decoder.sv
// -----------------------------------------------------------------------------
// instr_decoder
// Purely combinational opcode decoder.
// Ports:
//   opcode  in   4   instruction opcode (rom_data[7:4])
//   ctrl    out  ctrl_t  select, load strobes, immediate use, jump kind, illegal
// Undefined opcodes (1000, 1010, 1100, 1101) decode as a NOP with the
// illegal flag set; the spare load strobe is never produced.
// -----------------------------------------------------------------------------
module instr_decoder
    import cpu_pkg::*;
(
    input  logic [3:0] opcode,
    output ctrl_t      ctrl
);

    always_comb begin
        ctrl         = '0;
        ctrl.sel     = SEL_ZERO;
        case (opcode)
            OP_ADD_A_IM: begin ctrl.sel = SEL_A;    ctrl.load = 4'b0001; ctrl.use_imm = 1'b1; end
            OP_MOV_A_B:  begin ctrl.sel = SEL_B;    ctrl.load = 4'b0001; end
            OP_IN_A:     begin ctrl.sel = SEL_IN;   ctrl.load = 4'b0001; end
            OP_MOV_A_IM: begin ctrl.sel = SEL_ZERO; ctrl.load = 4'b0001; ctrl.use_imm = 1'b1; end
            OP_MOV_B_A:  begin ctrl.sel = SEL_A;    ctrl.load = 4'b0010; end
            OP_ADD_B_IM: begin ctrl.sel = SEL_B;    ctrl.load = 4'b0010; ctrl.use_imm = 1'b1; end
            OP_IN_B:     begin ctrl.sel = SEL_IN;   ctrl.load = 4'b0010; end
            OP_MOV_B_IM: begin ctrl.sel = SEL_ZERO; ctrl.load = 4'b0010; ctrl.use_imm = 1'b1; end
            OP_OUT_B:    begin ctrl.sel = SEL_B;    ctrl.load = 4'b0100; end
            OP_OUT_IM:   begin ctrl.sel = SEL_ZERO; ctrl.load = 4'b0100; ctrl.use_imm = 1'b1; end
            OP_JNC:      begin ctrl.use_imm = 1'b1; ctrl.is_jnc = 1'b1; end
            OP_JMP:      begin ctrl.use_imm = 1'b1; ctrl.is_jmp = 1'b1; end
            default:     ctrl.illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// -----------------------------------------------------------------------------
// instr_sequencer
// Control unit for the 4-bit datapath. Owns pc and the carry flag, fetches
// instructions from a synchronous ROM and drives the datapath controls for
// one cycle per instruction (FETCH, EXEC -> 2 cycles per instruction).
// Ports:
//   clk, n_reset        clock, synchronous active-low reset
//   run                 1 = keep executing, 0 = stop at next instruction boundary
//   rom_addr  out PC_W  ROM address (= pc)
//   rom_data  in  8     instruction, valid the cycle after rom_addr
//   alu_carry in  1     datapath carry-out for the current select/im
//   select_a, select_b  datapath source select
//   load0..load3        write strobes (A, B, OUT, spare)
//   im        out 4     immediate to the ALU
//   pc, cf, halted      architectural state / status
//   illegal             one-cycle pulse while executing an undefined opcode
// -----------------------------------------------------------------------------
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int PC_W = 4
)(
    input  logic            clk,
    input  logic            n_reset,
    input  logic            run,
    output logic [PC_W-1:0] rom_addr,
    input  logic [7:0]      rom_data,
    input  logic            alu_carry,
    output logic            select_a,
    output logic            select_b,
    output logic            load0,
    output logic            load1,
    output logic            load2,
    output logic            load3,
    output logic [3:0]      im,
    output logic [PC_W-1:0] pc,
    output logic            cf,
    output logic            halted,
    output logic            illegal
);

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc_nxt;
    logic            cf_nxt;
    ctrl_t           dec;
    logic            exec_act;
    logic [PC_W-1:0] imm_pc;

    instr_decoder u_decoder (
        .opcode (rom_data[7:4]),
        .ctrl   (dec)
    );

    // Reset gates the strobes combinationally so an instruction caught by
    // reset mid-EXEC never writes the datapath.
    assign exec_act = (state == ST_EXEC) && n_reset;
    assign imm_pc   = PC_W'(rom_data[3:0]);
    assign rom_addr = pc;
    assign halted   = (state == ST_HALT);

    always_comb begin
        {select_b, select_a} = SEL_ZERO;
        {load3, load2, load1, load0} = 4'b0000;
        im      = 4'd0;
        illegal = 1'b0;
        if (exec_act) begin
            {select_b, select_a} = dec.sel;
            {load3, load2, load1, load0} = dec.load;
            im      = dec.use_imm ? rom_data[3:0] : 4'd0;
            illegal = dec.illegal;
        end
    end

    always_comb begin
        state_nxt = state;
        pc_nxt    = pc;
        cf_nxt    = cf;
        case (state)
            ST_HALT: begin
                if (run) state_nxt = ST_FETCH;
            end
            ST_FETCH: begin
                state_nxt = ST_EXEC;
            end
            ST_EXEC: begin
                // JNC tests the flag as it stood before this instruction.
                cf_nxt = alu_carry;
                if (dec.is_jmp || (dec.is_jnc && !cf))
                    pc_nxt = imm_pc;
                else
                    pc_nxt = pc + PC_W'(1);
                state_nxt = run ? ST_FETCH : ST_HALT;
            end
            default: state_nxt = ST_HALT;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!n_reset) begin
            state <= ST_HALT;
            pc    <= '0;
            cf    <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            cf    <= cf_nxt;
        end
    end

endmodule

// File: tb/tb_instr_sequencer.sv
// -----------------------------------------------------------------------------
// tb_instr_sequencer
// Self-checking bench: a synchronous ROM model feeds the sequencer, and an
// instruction-level reference model predicts pc, cf, status and the control
// outputs every cycle. Directed programs come first, then random programs
// with random run / carry / reset activity.
// -----------------------------------------------------------------------------
module tb_instr_sequencer;

    localparam int PC_W = 4;

    logic            clk = 1'b0;
    logic            n_reset = 1'b0;
    logic            run = 1'b0;
    logic            alu_carry = 1'b0;
    logic [PC_W-1:0] rom_addr;
    logic [7:0]      rom_data;
    logic            select_a, select_b;
    logic            load0, load1, load2, load3;
    logic [3:0]      im;
    logic [PC_W-1:0] pc;
    logic            cf, halted, illegal;

    logic [7:0] rom [16];

    int checks = 0;
    int errors = 0;

    // Reference model: phase 0 = stopped, 1 = fetching, 2 = executing.
    int         m_phase = 0;
    logic [3:0] m_pc = 4'd0;
    logic       m_cf = 1'b0;
    logic [7:0] m_ir = 8'h00;

    instr_sequencer #(.PC_W(PC_W)) dut (
        .clk       (clk),
        .n_reset   (n_reset),
        .run       (run),
        .rom_addr  (rom_addr),
        .rom_data  (rom_data),
        .alu_carry (alu_carry),
        .select_a  (select_a),
        .select_b  (select_b),
        .load0     (load0),
        .load1     (load1),
        .load2     (load2),
        .load3     (load3),
        .im        (im),
        .pc        (pc),
        .cf        (cf),
        .halted    (halted),
        .illegal   (illegal)
    );

    always #5 clk = ~clk;

    always @(posedge clk) rom_data <= rom[rom_addr];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Instruction semantics: {select[1:0], load[3:0], im[3:0], illegal}.
    // Sources: 0=A 1=B 2=IN 3=zero.  Destinations: A=0001 B=0010 OUT=0100.
    function automatic logic [10:0] ref_ctl(input logic [7:0] ir);
        logic [3:0] imm;
        imm = ir[3:0];
        case (ir[7:4])
            4'h0:    ref_ctl = {2'd0, 4'b0001, imm,  1'b0}; // ADD A,Im
            4'h1:    ref_ctl = {2'd1, 4'b0001, 4'd0, 1'b0}; // MOV A,B
            4'h2:    ref_ctl = {2'd2, 4'b0001, 4'd0, 1'b0}; // IN A
            4'h3:    ref_ctl = {2'd3, 4'b0001, imm,  1'b0}; // MOV A,Im
            4'h4:    ref_ctl = {2'd0, 4'b0010, 4'd0, 1'b0}; // MOV B,A
            4'h5:    ref_ctl = {2'd1, 4'b0010, imm,  1'b0}; // ADD B,Im
            4'h6:    ref_ctl = {2'd2, 4'b0010, 4'd0, 1'b0}; // IN B
            4'h7:    ref_ctl = {2'd3, 4'b0010, imm,  1'b0}; // MOV B,Im
            4'h9:    ref_ctl = {2'd1, 4'b0100, 4'd0, 1'b0}; // OUT B
            4'hB:    ref_ctl = {2'd3, 4'b0100, imm,  1'b0}; // OUT Im
            4'hE:    ref_ctl = {2'd3, 4'b0000, imm,  1'b0}; // JNC Im
            4'hF:    ref_ctl = {2'd3, 4'b0000, imm,  1'b0}; // JMP Im
            default: ref_ctl = {2'd3, 4'b0000, 4'd0, 1'b1}; // undefined -> NOP
        endcase
    endfunction

    // One clock cycle: drive inputs after the falling edge, compare all
    // outputs against the model, then advance the model to the next cycle.
    task automatic cyc(input logic r, input logic c, input logic nr);
        logic [10:0] exp_ctl;
        logic        taken;
        @(negedge clk);
        run       = r;
        alu_carry = c;
        n_reset   = nr;
        #1;
        exp_ctl = {2'd3, 4'b0000, 4'd0, 1'b0};
        if (nr && m_phase == 2) exp_ctl = ref_ctl(m_ir);
        check_eq("ctl", {select_b, select_a, load3, load2, load1, load0, im, illegal}, exp_ctl);
        check_eq("pc", pc, m_pc);
        check_eq("rom_addr", rom_addr, m_pc);
        check_eq("cf", cf, m_cf);
        check_eq("halted", halted, (m_phase == 0));
        if (!nr) begin
            m_phase = 0;
            m_pc    = 4'd0;
            m_cf    = 1'b0;
        end else begin
            case (m_phase)
                0: if (r) m_phase = 1;
                1: begin
                    m_ir    = rom[m_pc];
                    m_phase = 2;
                end
                default: begin
                    taken   = (m_ir[7:4] == 4'hF) || (m_ir[7:4] == 4'hE && !m_cf);
                    m_cf    = c;
                    m_pc    = taken ? m_ir[3:0] : m_pc + 4'd1;
                    m_phase = r ? 1 : 0;
                end
            endcase
        end
    endtask

    initial begin
        for (int i = 0; i < 16; i++) rom[i] = 8'h00;
        rom[0]  = 8'h35;  // MOV A,5
        rom[1]  = 8'h0F;  // ADD A,15 (carry driven 1)
        rom[2]  = 8'hE7;  // JNC 7, cf=1 -> fall through
        rom[3]  = 8'h0F;  // ADD A,15 (carry driven 0)
        rom[4]  = 8'hE7;  // JNC 7, cf=0 -> taken
        rom[7]  = 8'hA0;  // undefined
        rom[8]  = 8'hFF;  // JMP 15
        rom[15] = 8'h00;  // ADD A,0 at pc 15 -> wrap

        cyc(0, 0, 0);
        cyc(0, 0, 0);
        check_eq("reset_halted", halted, 1);
        check_eq("reset_pc", pc, 0);

        cyc(1, 0, 1);                                  // HALT -> FETCH
        cyc(1, 0, 1);
        check_eq("fetch_addr", rom_addr, 0);
        cyc(1, 0, 1);                                  // EXEC MOV A,5
        check_eq("mov_a_load0", load0, 1);
        check_eq("mov_a_im", im, 5);
        check_eq("mov_a_sel", {select_b, select_a}, 3);
        cyc(1, 0, 1);
        check_eq("pc_after_mov", pc, 1);
        cyc(1, 1, 1);                                  // EXEC ADD with carry
        cyc(1, 0, 1);
        check_eq("cf_set", cf, 1);
        cyc(1, 0, 1);                                  // EXEC JNC, cf=1
        cyc(1, 0, 1);
        check_eq("jnc_not_taken", pc, 3);
        cyc(1, 0, 1);                                  // EXEC ADD, no carry
        cyc(1, 0, 1);
        cyc(1, 0, 1);                                  // EXEC JNC, cf=0
        cyc(1, 0, 1);
        check_eq("jnc_taken", pc, 7);
        cyc(1, 0, 1);                                  // EXEC undefined
        check_eq("illegal_pulse", illegal, 1);
        check_eq("illegal_noload", {load3, load2, load1, load0}, 0);
        cyc(1, 0, 1);
        check_eq("illegal_clear", illegal, 0);
        check_eq("illegal_pc", pc, 8);
        cyc(1, 0, 1);                                  // EXEC JMP 15
        cyc(1, 0, 1);
        check_eq("jmp_pc", pc, 15);
        cyc(1, 0, 1);                                  // EXEC at pc 15
        cyc(0, 0, 1);                                  // FETCH, run dropped
        check_eq("pc_wrap", pc, 0);
        cyc(0, 0, 1);                                  // EXEC still completes
        check_eq("drop_exec_load0", load0, 1);
        cyc(0, 0, 1);
        check_eq("drop_halted", halted, 1);
        check_eq("drop_pc", pc, 1);
        cyc(0, 0, 1);
        check_eq("hold_pc", pc, 1);

        rom[1] = 8'h45;                                // MOV B,A, cut by reset
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        cyc(1, 1, 0);
        check_eq("rst_exec_load1", load1, 0);
        cyc(0, 0, 1);
        check_eq("rst_exec_pc", pc, 0);
        check_eq("rst_exec_cf", cf, 0);
        check_eq("rst_exec_halted", halted, 1);

        rom[0] = 8'hF4;                                // JMP 4
        rom[4] = 8'hF3;                                // JMP 3
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        cyc(1, 0, 1);
        check_eq("jmp4_pc", pc, 4);
        cyc(1, 0, 1);
        check_eq("jmp_noload", {load3, load2, load1, load0}, 0);
        cyc(1, 0, 1);
        check_eq("jmp3_pc", pc, 3);

        cyc(0, 0, 0);
        for (int i = 0; i < 16; i++) rom[i] = 8'($urandom);
        for (int i = 0; i < 3000; i++) begin
            cyc(($urandom_range(0, 9) != 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 199) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Control unit for the 4-bit datapath: owns the program counter and carry flag, fetches 8-bit instructions from a synchronous program ROM, decodes them, and drives the datapath's control inputs (select_a, select_b, load0..load3, im) one instruction at a time. The datapath's ALU carry-out and immediate path are reused unchanged. Sits between the program ROM and the datapath in the CPU top level.

## Interface
- PC_W, 4, program counter / ROM address width; PC wraps modulo 2^PC_W.
- clk  in  1  clock.
- n_reset  in  1  reset n_reset, synchronous, active-low; clock clk.
- run  in  1  level; 1 = execute continuously, 0 = stop at next instruction boundary.
- rom_addr  out  PC_W  ROM read address, equals pc.
- rom_data  in  8  instruction, valid one cycle after rom_addr (synchronous ROM); [7:4] opcode, [3:0] immediate.
- alu_carry  in  1  datapath ALU carry-out, combinational from select/im.
- select_a, select_b  out  1 each  source select {select_b,select_a}: 00=A, 01=B, 10=IN port, 11=zero.
- load0, load1, load2, load3  out  1 each  one-cycle write strobes to A, B, OUT, and spare (load3 never asserted).
- im  out  4  immediate to ALU.
- pc  out  PC_W  current program counter.
- cf  out  1  carry flag.
- halted  out  1  1 in HALT state.
- illegal  out  1  one-cycle pulse on undefined opcode.

## Operation
- States: HALT, FETCH, EXEC.
- HALT: run=1 -> FETCH; else stay.
- FETCH: rom_addr=pc; all loads 0, select=11, im=0; -> EXEC.
- EXEC: decode rom_data; assert one load strobe/select/im for exactly this cycle; at clock edge: cf <= alu_carry, pc updates; -> FETCH if run=1, else HALT.
- Opcodes (select, load, im): 0000 ADD A,Im (A, load0, imm); 0001 MOV A,B (B, load0, 0); 0010 IN A (IN, load0, 0); 0011 MOV A,Im (zero, load0, imm); 0100 MOV B,A (A, load1, 0); 0101 ADD B,Im (B, load1, imm); 0110 IN B (IN, load1, 0); 0111 MOV B,Im (zero, load1, imm); 1001 OUT B (B, load2, 0); 1011 OUT Im (zero, load2, imm); 1110 JNC Im (zero, none, imm); 1111 JMP Im (zero, none, imm).
- 1000, 1010, 1100, 1101: NOP (no load, select=11, im=0), illegal=1 during EXEC, pc+1.
- pc update: JMP -> imm; JNC -> imm if cf==0 (flag value before this instruction's update) else pc+1; otherwise pc+1 modulo 2^PC_W (15 -> 0 for PC_W=4).
- cf updated at every EXEC, including MOV/JMP/NOP (carry of selected+im); never updated in FETCH or HALT.
- run sampled only in HALT and at end of EXEC; an instruction in flight always completes.

## Timing
- Reset values: state HALT, pc=0, cf=0, rom_addr=0, loads=0, select=11, im=0, halted=1, illegal=0.
- n_reset low forces all load strobes and illegal to 0 combinationally in that cycle; reset mid-EXEC discards the instruction (no pc/cf update).
- Throughput: 2 cycles per instruction; strobes asserted only in EXEC.
- run rising while HALT: FETCH next cycle, first strobe 2 cycles after run seen.
- Control outputs are combinational from state and rom_data; pc, cf, state registered.

## Structure
- Shared package cpu_pkg: opcode constants (OP_ADD_A_IM ... OP_JMP), source-select encodings (SEL_A, SEL_B, SEL_IN, SEL_ZERO), state enum.
- Sub-module instr_decoder: purely combinational opcode -> {select_b, select_a, load[3:0], use_imm, is_jmp, is_jnc, illegal}. Sequencer holds FSM, pc, cf.

## Test plan
- Reset then run=1, ROM[0]=0x35 (MOV A,5) -> cycle 1 FETCH addr 0, cycle 2 load0=1, select=11, im=5; pc=1 after.
- ADD A,Im with alu_carry=1 driven (0x0F) -> cf=1 after EXEC; next 0xE7 (JNC 7) -> pc=pc+1, not 7; with cf=0 -> pc=7.
- pc=15 executing 0x00 -> pc wraps to 0; 0xF3 at pc=4 -> pc=3, no load strobe.
- Opcode 0xA0 -> illegal pulse 1 cycle, no load, pc+1, FSM continues.
- run dropped during FETCH -> EXEC completes, then HALT with halted=1, pc held; run=1 resumes at held pc.
- n_reset low during EXEC of 0x45 -> load1 stays 0, pc=0, cf=0, HALT next cycle.
